// File: rtl/viz_pkg.sv
// Shared constants and types for the sample framer: frame geometry,
// the Hann window ROM and the framer state encoding.
package viz_pkg;

  localparam int FRAME_LEN = 16;
  localparam int SAMPLE_W  = 10;
  localparam int COEF_W    = 9;
  localparam int OUT_W     = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2
  } state_e;

  // 16-point Hann window, Q8 unsigned (256 = unity)
  localparam logic [COEF_W-1:0] WIN_ROM [FRAME_LEN] = '{
    9'd0,   9'd11,  9'd42,  9'd88,  9'd141, 9'd192, 9'd232, 9'd253,
    9'd253, 9'd232, 9'd192, 9'd141, 9'd88,  9'd42,  9'd11,  9'd0
  };

  // Coefficient for a frame position; unity gain when windowing is off
  function automatic logic [COEF_W-1:0] win_coef(input logic [3:0] idx, input bit en);
    return en ? WIN_ROM[idx] : 9'd256;
  endfunction

endpackage

// File: rtl/sample_framer_window_mult.sv
// Combinational window multiply: signed sample times unsigned Q8
// coefficient, floor shift by 8, sign-extended to the output width.
module window_mult
  import viz_pkg::*;
(
  input  logic signed [SAMPLE_W-1:0] i_sample,
  input  logic        [COEF_W-1:0]   i_coef,
  output logic signed [OUT_W-1:0]    o_data
);

  // One guard bit above the 19-bit product so the unsigned coefficient
  // can be widened to a non-negative signed operand.
  localparam int PROD_W = SAMPLE_W + COEF_W + 1;

  logic signed [COEF_W:0]   w_coef_s;
  logic signed [PROD_W-1:0] w_prod;

  // Arithmetic shift floors toward minus infinity; the result fits in
  // 12 bits, so narrowing to 16 preserves the sign extension.
  function automatic logic signed [OUT_W-1:0] floor_shift(input logic signed [PROD_W-1:0] p);
    return OUT_W'(p >>> 8);
  endfunction

  assign w_coef_s = signed'({1'b0, i_coef});
  assign w_prod   = i_sample * w_coef_s;
  assign o_data   = floor_shift(w_prod);

endmodule

// File: rtl/sample_framer.sv
// Sample framer: every HOP new samples (once 16 have been seen) it
// snapshots the 16-deep history, then streams the windowed frame out
// over a valid/ready handshake. Triggers arriving mid-frame are dropped
// and counted.
module sample_framer
  import viz_pkg::*;
#(
  parameter int HOP    = 16,
  parameter int WIN_EN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        new_t,
  input  logic [15:0] t0,
  input  logic [15:0] t1,
  input  logic [15:0] t2,
  input  logic [15:0] t3,
  input  logic [15:0] t4,
  input  logic [15:0] t5,
  input  logic [15:0] t6,
  input  logic [15:0] t7,
  input  logic [15:0] t8,
  input  logic [15:0] t9,
  input  logic [15:0] t10,
  input  logic [15:0] t11,
  input  logic [15:0] t12,
  input  logic [15:0] t13,
  input  logic [15:0] t14,
  input  logic [15:0] t15,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [3:0]  out_index,
  output logic        out_last,
  output logic        overrun,
  output logic [7:0]  drop_cnt
);

  logic        [SAMPLE_W-1:0] w_hist [FRAME_LEN];
  logic signed [SAMPLE_W-1:0] r_buf  [FRAME_LEN];

  state_e                  r_state;
  logic [3:0]              r_hop;
  logic [4:0]              r_fill;
  logic                    r_valid;
  logic signed [OUT_W-1:0] r_data;
  logic [3:0]              r_index;
  logic                    r_last;
  logic                    r_overrun;
  logic [7:0]              r_drop;

  logic                    w_trig;
  logic                    w_last_hs;
  logic                    w_capture;
  logic                    w_drop;
  logic [3:0]              w_sel;
  logic [COEF_W-1:0]       w_coef;
  logic signed [OUT_W-1:0] w_win;
  logic                    w_unused;

  // Oldest sample lands in entry 0 so the frame streams oldest-first.
  assign w_hist[0]  = t15[SAMPLE_W-1:0];
  assign w_hist[1]  = t14[SAMPLE_W-1:0];
  assign w_hist[2]  = t13[SAMPLE_W-1:0];
  assign w_hist[3]  = t12[SAMPLE_W-1:0];
  assign w_hist[4]  = t11[SAMPLE_W-1:0];
  assign w_hist[5]  = t10[SAMPLE_W-1:0];
  assign w_hist[6]  = t9[SAMPLE_W-1:0];
  assign w_hist[7]  = t8[SAMPLE_W-1:0];
  assign w_hist[8]  = t7[SAMPLE_W-1:0];
  assign w_hist[9]  = t6[SAMPLE_W-1:0];
  assign w_hist[10] = t5[SAMPLE_W-1:0];
  assign w_hist[11] = t4[SAMPLE_W-1:0];
  assign w_hist[12] = t3[SAMPLE_W-1:0];
  assign w_hist[13] = t2[SAMPLE_W-1:0];
  assign w_hist[14] = t1[SAMPLE_W-1:0];
  assign w_hist[15] = t0[SAMPLE_W-1:0];

  // Upper history bits carry no sample information.
  assign w_unused = ^{t0[15:10], t1[15:10], t2[15:10], t3[15:10], t4[15:10], t5[15:10],
                      t6[15:10], t7[15:10], t8[15:10], t9[15:10], t10[15:10], t11[15:10],
                      t12[15:10], t13[15:10], t14[15:10], t15[15:10]};

  // The current pulse completes the 16th sample when fill_cnt is already 15.
  assign w_trig    = new_t && (r_hop == 4'(HOP - 1)) && (r_fill >= 5'd15);
  assign w_last_hs = r_valid && out_ready && r_last;
  assign w_capture = reset && w_trig &&
                     ((r_state == IDLE) || ((r_state == STREAM) && w_last_hs));
  assign w_drop    = reset && w_trig && !w_capture && (r_state != IDLE);

  // LOAD presents entry 0; STREAM prefetches the entry after the current one.
  assign w_sel  = (r_state == LOAD) ? 4'd0 : r_index + 4'd1;
  assign w_coef = win_coef(w_sel, WIN_EN != 0);

  window_mult u_win (
    .i_sample (r_buf[w_sel]),
    .i_coef   (w_coef),
    .o_data   (w_win)
  );

  // Hop and fill counters advance on every new sample regardless of state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hop  <= '0;
      r_fill <= '0;
    end else if (new_t) begin
      r_hop  <= (r_hop == 4'(HOP - 1)) ? 4'd0 : r_hop + 4'd1;
      r_fill <= (r_fill == 5'd16) ? r_fill : r_fill + 5'd1;
    end
  end

  // Frame buffer snapshot; contents only matter once a frame is accepted.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      for (int i = 0; i < FRAME_LEN; i++) r_buf[i] <= w_hist[i];
    end
  end

  // Framer FSM with registered stream outputs and drop accounting.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_index   <= '0;
      r_last    <= 1'b0;
      r_overrun <= 1'b0;
      r_drop    <= '0;
    end else begin
      if (w_drop) begin
        r_overrun <= 1'b1;
        if (r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
      end
      case (r_state)
        IDLE: begin
          if (w_capture) r_state <= LOAD;
        end
        LOAD: begin
          r_data  <= w_win;
          r_index <= 4'd0;
          r_last  <= 1'b0;
          r_valid <= 1'b1;
          r_state <= STREAM;
        end
        STREAM: begin
          if (r_valid && out_ready) begin
            if (r_last) begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_state <= w_capture ? LOAD : IDLE;
            end else begin
              r_data  <= w_win;
              r_index <= r_index + 4'd1;
              r_last  <= (r_index == 4'd14);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_index = r_index;
  assign out_last  = r_last;
  assign overrun   = r_overrun;
  assign drop_cnt  = r_drop;

endmodule

// File: tb/tb_sample_framer.sv
// Directed bench for sample_framer: three instances cover the windowed
// default, the pass-through configuration and a short hop.
module tb_sample_framer;

  logic        clk = 1'b0;
  logic        new_t;
  logic [15:0] t [16];
  logic        ra, rb, rc;
  logic        rdy_a, rdy_b, rdy_c;

  logic        va, la, oa, vb, lb, ob, vc, lc, oc;
  logic [15:0] da, db, dc;
  logic [3:0]  ia, ib, ic;
  logic [7:0]  ca, cb, cc;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  int exp_pos [16] = '{0, 4, 16, 34, 55, 75, 90, 98, 98, 90, 75, 55, 34, 16, 4, 0};

  always #5 clk = ~clk;

  sample_framer #(.HOP(16), .WIN_EN(1)) u_a (
    .clk(clk), .reset(ra), .new_t(new_t),
    .t0(t[0]), .t1(t[1]), .t2(t[2]), .t3(t[3]), .t4(t[4]), .t5(t[5]), .t6(t[6]), .t7(t[7]),
    .t8(t[8]), .t9(t[9]), .t10(t[10]), .t11(t[11]), .t12(t[12]), .t13(t[13]), .t14(t[14]), .t15(t[15]),
    .out_valid(va), .out_ready(rdy_a), .out_data(da), .out_index(ia), .out_last(la),
    .overrun(oa), .drop_cnt(ca));

  sample_framer #(.HOP(16), .WIN_EN(0)) u_b (
    .clk(clk), .reset(rb), .new_t(new_t),
    .t0(t[0]), .t1(t[1]), .t2(t[2]), .t3(t[3]), .t4(t[4]), .t5(t[5]), .t6(t[6]), .t7(t[7]),
    .t8(t[8]), .t9(t[9]), .t10(t[10]), .t11(t[11]), .t12(t[12]), .t13(t[13]), .t14(t[14]), .t15(t[15]),
    .out_valid(vb), .out_ready(rdy_b), .out_data(db), .out_index(ib), .out_last(lb),
    .overrun(ob), .drop_cnt(cb));

  sample_framer #(.HOP(4), .WIN_EN(1)) u_c (
    .clk(clk), .reset(rc), .new_t(new_t),
    .t0(t[0]), .t1(t[1]), .t2(t[2]), .t3(t[3]), .t4(t[4]), .t5(t[5]), .t6(t[6]), .t7(t[7]),
    .t8(t[8]), .t9(t[9]), .t10(t[10]), .t11(t[11]), .t12(t[12]), .t13(t[13]), .t14(t[14]), .t15(t[15]),
    .out_valid(vc), .out_ready(rdy_c), .out_data(dc), .out_index(ic), .out_last(lc),
    .overrun(oc), .drop_cnt(cc));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; each pulse spans one rising edge plus an idle one.
  task automatic pulse(input int n);
    repeat (n) begin
      new_t = 1'b1;
      @(negedge clk);
      new_t = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic set_all(input logic [15:0] v);
    for (int i = 0; i < 16; i++) t[i] = v;
  endtask

  initial begin
    new_t = 1'b0;
    ra = 1'b0; rb = 1'b0; rc = 1'b0;
    rdy_a = 1'b0; rdy_b = 1'b0; rdy_c = 1'b0;
    set_all(16'h0000);
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_valid", va, 0);
    chk("rst_data", da, 0);
    chk("rst_index", ia, 0);
    chk("rst_last", la, 0);
    chk("rst_overrun", oa, 0);
    chk("rst_drop", ca, 0);

    // Warm-up then first windowed frame of +100 samples
    ra = 1'b1;
    rdy_a = 1'b1;
    set_all(16'h0064);
    pulse(15);
    chk("a_warm15_valid", va, 0);
    new_t = 1'b1;
    @(negedge clk);
    new_t = 1'b0;
    chk("a_load_valid", va, 0);
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      chk("a_f1_valid", va, 1);
      chk("a_f1_index", ia, k);
      chk("a_f1_data", da, 32'(exp_pos[k]));
      chk("a_f1_last", la, (k == 15) ? 1 : 0);
      @(negedge clk);
    end
    chk("a_f1_end_valid", va, 0);
    @(negedge clk);
    chk("a_f1_idle_valid", va, 0);

    // Backpressure pattern 1,0,0,1 on -100 samples (upper bits set)
    rdy_a = 1'b0;
    set_all(16'hFF9C);
    pulse(16);
    chk("a_bp_idx0", ia, 0);
    chk("a_bp_valid0", va, 1);
    rdy_a = 1'b1;
    @(negedge clk);
    chk("a_bp_idx1", ia, 1);
    chk("a_bp_data1", da, 16'hFFFB);
    rdy_a = 1'b0;
    @(negedge clk);
    chk("a_bp_hold1_idx", ia, 1);
    chk("a_bp_hold1_data", da, 16'hFFFB);
    @(negedge clk);
    chk("a_bp_hold2_idx", ia, 1);
    chk("a_bp_hold2_data", da, 16'hFFFB);
    rdy_a = 1'b1;
    @(negedge clk);
    chk("a_bp_idx2", ia, 2);
    chk("a_bp_data2", da, 16'hFFEF);
    @(negedge clk);
    chk("a_bp_idx3", ia, 3);
    chk("a_bp_data3", da, 16'hFFDD);
    @(negedge clk);
    chk("a_bp_data4", da, 16'hFFC8);
    for (int k = 4; k < 16; k++) begin
      chk("a_bp_index", ia, k);
      chk("a_bp_last", la, (k == 15) ? 1 : 0);
      @(negedge clk);
    end
    chk("a_bp_end_valid", va, 0);

    // Frame stalled by out_ready=0, next trigger is dropped
    rdy_a = 1'b0;
    pulse(16);
    chk("a_ov_pre_overrun", oa, 0);
    chk("a_ov_pre_valid", va, 1);
    pulse(16);
    chk("a_ov_overrun", oa, 1);
    chk("a_ov_drop1", ca, 1);
    chk("a_ov_held_idx", ia, 0);
    chk("a_ov_held_valid", va, 1);
    new_t = 1'b1;
    repeat (16 * 299) @(negedge clk);
    new_t = 1'b0;
    @(negedge clk);
    chk("a_ov_drop_sat", ca, 8'hFF);
    chk("a_ov_overrun_sticky", oa, 1);

    // Reset mid-frame at index 7
    rdy_a = 1'b1;
    repeat (7) @(negedge clk);
    chk("a_mid_idx7", ia, 7);
    ra = 1'b0;
    @(negedge clk);
    chk("a_mid_valid", va, 0);
    chk("a_mid_last", la, 0);
    chk("a_mid_drop", ca, 0);
    chk("a_mid_overrun", oa, 0);
    ra = 1'b1;
    pulse(15);
    chk("a_rewarm15_valid", va, 0);
    pulse(1);
    chk("a_rewarm16_valid", va, 1);
    chk("a_rewarm16_idx", ia, 0);
    ra = 1'b0;

    // Pass-through: -1, -512, +511 with junk in the ignored upper bits
    rb = 1'b1;
    rdy_b = 1'b1;
    set_all(16'h0000);
    t[15] = 16'hA7FF;
    t[14] = 16'h5600;
    t[13] = 16'h01FF;
    pulse(16);
    chk("b_valid", vb, 1);
    chk("b_data0", db, 16'hFFFF);
    chk("b_last0", lb, 0);
    @(negedge clk);
    chk("b_idx1", ib, 1);
    chk("b_data1", db, 16'hFE00);
    @(negedge clk);
    chk("b_data2", db, 16'h01FF);
    chk("b_overrun", ob, 0);
    chk("b_drop", cb, 0);
    rb = 1'b0;

    // HOP=4: 16-pulse warm-up, trigger on the final handshake accepted
    rc = 1'b1;
    rdy_c = 1'b1;
    set_all(16'h0064);
    pulse(15);
    chk("c_warm15_valid", vc, 0);
    new_t = 1'b1;
    @(negedge clk);
    new_t = 1'b0;
    chk("c_load_valid", vc, 0);
    @(negedge clk);
    chk("c_f1_valid", vc, 1);
    chk("c_f1_idx0", ic, 0);
    for (int cyc = 2; cyc <= 17; cyc++) begin
      new_t = (cyc >= 14);
      @(negedge clk);
      if (cyc == 4) chk("c_f1_data3", dc, 34);
      if (cyc == 16) begin
        chk("c_f1_idx15", ic, 15);
        chk("c_f1_last", lc, 1);
      end
    end
    new_t = 1'b0;
    chk("c_coinc_valid", vc, 0);
    chk("c_coinc_overrun", oc, 0);
    chk("c_coinc_drop", cc, 0);
    @(negedge clk);
    chk("c_f2_valid", vc, 1);
    chk("c_f2_idx0", ic, 0);
    repeat (15) @(negedge clk);
    chk("c_f2_idx15", ic, 15);
    chk("c_f2_last", lc, 1);
    @(negedge clk);
    chk("c_f2_end_valid", vc, 0);
    pulse(3);
    chk("c_hop3_valid", vc, 0);
    pulse(1);
    chk("c_hop4_valid", vc, 1);
    chk("c_hop4_idx", ic, 0);
    chk("c_hop4_drop", cc, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sample_framer.md
SAMPLE_FRAMER -- requirements
Module: sample_framer

Interface
REQ-001 SHALL have parameter HOP, default 16, meaning new samples between frame triggers (legal 1..16).
REQ-002 SHALL have parameter WIN_EN, default 1, meaning 1 = apply Hann window and 0 = pass-through.
REQ-003 SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-004 SHALL have port reset, input, 1 bit, synchronous, active-low reset.
REQ-005 SHALL have port new_t, input, 1 bit, one-cycle pulse marking that t0..t15 has shifted in a new sample.
REQ-006 SHALL have ports t0..t15, input, 16 bits each, sample history; t0 newest, t15 oldest; bits [9:0] are 10-bit two's complement and bits [15:10] are ignored.
REQ-007 SHALL have port out_valid, output, 1 bit, out_data valid.
REQ-008 SHALL have port out_ready, input, 1 bit, downstream FFT accepts.
REQ-009 SHALL have port out_data, output, 16 bits, windowed sample, signed.
REQ-010 SHALL have port out_index, output, 4 bits, position of the sample in the frame.
REQ-011 SHALL have port out_last, output, 1 bit, high with index 15.
REQ-012 SHALL have port overrun, output, 1 bit, sticky frame-dropped flag.
REQ-013 SHALL have port drop_cnt, output, 8 bits, saturating count of dropped frames.

Function
REQ-014 SHALL count new_t pulses in hop_cnt, wrapping at HOP-1 to 0, and in fill_cnt, saturating at 16.
REQ-015 SHALL raise a trigger when new_t=1, hop_cnt=HOP-1 and fill_cnt is at least 15 (the current pulse makes 16).
REQ-016 SHALL use the states IDLE, LOAD and STREAM.
REQ-017 SHALL, on a trigger in IDLE at edge N, copy t15..t0 into frame buffer entries 0..15 at edge N and enter LOAD.
REQ-018 SHALL, in LOAD, register windowed entry 0 into out_data, set out_index=0 and out_valid=1 at edge N+1, then enter STREAM.
REQ-019 SHALL hold out_data, out_index and out_last stable in STREAM while out_valid=1 and out_ready=0.
REQ-020 SHALL, on out_valid&out_ready with index i<15, register entry i+1 and index i+1 on the same edge, giving no bubble.
REQ-021 SHALL, on out_valid&out_ready with index 15 (out_last=1), clear out_valid and return to IDLE.
REQ-022 SHALL, if a trigger coincides with the last handshake, accept it: capture the buffer and enter LOAD.
REQ-023 SHALL, on a trigger while in LOAD or STREAM (other than the REQ-022 case), drop the frame: keep the buffer unchanged, set overrun=1 and increment drop_cnt, saturating at 255.
REQ-024 SHALL keep hop_cnt advancing regardless of state.
REQ-025 SHALL compute the window as x = sign-extend(buffer[i][9:0]) times unsigned 9-bit coefficient w[i], giving a 19-bit signed product.
REQ-026 SHALL arithmetic-shift the product right by 8 (floor) and sign-extend the result to 16 bits.
REQ-027 SHALL use w[0..15] = 0, 11, 42, 88, 141, 192, 232, 253, 253, 232, 192, 141, 88, 42, 11, 0.
REQ-028 SHALL, with WIN_EN=0, use w = 256 for every index, so out_data = sign-extend(x).
REQ-029 SHALL never assert out_valid in IDLE.

Reset
REQ-030 SHALL, when reset=0 at a clock edge, set: state IDLE, hop_cnt=0, fill_cnt=0, out_valid=0, out_data=0, out_index=0, out_last=0, overrun=0, drop_cnt=0.
REQ-031 SHALL, on reset mid-frame, abort the frame immediately with no out_last; the buffer contents are don't-care.

Structure
REQ-032 SHALL place the window ROM constant, the state enum, FRAME_LEN=16 and SAMPLE_W=10 in shared package viz_pkg.
REQ-033 SHALL contain one sub-module, window_mult: a combinational signed-by-unsigned multiply with floor shift and sign-extend.
REQ-034 SHALL have no other hierarchy.

Verification
REQ-035 SHALL cover: reset, then 16 new_t pulses with all samples = 10'h064 (+100) and out_ready=1 -> out_valid rises one edge after the 16th pulse; out_data = 0, 4, 16, 34, 55, 75, 90, 98, 98, ..., 0; out_last at index 15; then IDLE.
REQ-036 SHALL cover: WIN_EN=0 with samples of 10'h3FF (-1) and 10'h200 (-512) -> out_data = 16'hFFFF and 16'hFE00.
REQ-037 SHALL cover: out_ready toggling 1,0,0,1 during STREAM -> data and index held during the 0 cycles, no skipped or duplicate index.
REQ-038 SHALL cover: out_ready=0 throughout with 16 further new_t pulses -> trigger dropped, overrun=1, drop_cnt=1; 300 drops -> drop_cnt=255.
REQ-039 SHALL cover: HOP=4 -> first frame only after 16 pulses from reset, later frames every 4 pulses; a trigger coinciding with the last handshake is accepted with no drop.
REQ-040 SHALL cover: reset asserted at index 7 -> out_valid=0 next edge, no out_last, and a clean 16-pulse warm-up is needed before the next frame.
